// File: rtl/alu_ctrl_md_if.sv
// rtl/alu_ctrl_md_if.sv - instruction/result bundle between pipeline and ALU control/mul-div unit
interface alu_ctrl_md_if #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
);
   logic              valid_i;
   logic [5:0]        funct_i;
   logic [2:0]        ALUop_i;
   logic [WIDTH-1:0]  src1_i;
   logic [WIDTH-1:0]  src2_i;
   logic [CTRL_W-1:0] ALUCtrl_o;
   logic              stall_o;
   logic              md_done_o;
   logic [WIDTH-1:0]  hi_o;
   logic [WIDTH-1:0]  lo_o;

   modport master (
      output valid_i, funct_i, ALUop_i, src1_i, src2_i,
      input  ALUCtrl_o, stall_o, md_done_o, hi_o, lo_o
   );

   modport slave (
      input  valid_i, funct_i, ALUop_i, src1_i, src2_i,
      output ALUCtrl_o, stall_o, md_done_o, hi_o, lo_o
   );
endinterface

// File: rtl/alu_ctrl_md.sv
// rtl/alu_ctrl_md.sv - ALU control decoder with iterative multiply/divide and HI/LO registers
module alu_ctrl_md #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   alu_ctrl_md_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4'b0000);
   localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(4'b0001);
   localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(4'b0010);
   localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(4'b0011);
   localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(4'b0100);
   localparam logic [CTRL_W-1:0] C_LW   = CTRL_W'(4'b0101);
   localparam logic [CTRL_W-1:0] C_SW   = CTRL_W'(4'b0110);
   localparam logic [CTRL_W-1:0] C_BEQ  = CTRL_W'(4'b0111);
   localparam logic [CTRL_W-1:0] C_MFHI = CTRL_W'(4'b1000);
   localparam logic [CTRL_W-1:0] C_MFLO = CTRL_W'(4'b1001);
   localparam logic [CTRL_W-1:0] C_MD   = CTRL_W'(4'b1010);
   localparam logic [CTRL_W-1:0] C_INV  = CTRL_W'(4'b1111);

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  acc_hi;      // partial product upper half / partial remainder
   logic [WIDTH-1:0]  acc_lo;      // multiplier shifting out / dividend shifting into quotient
   logic [WIDTH-1:0]  opb;         // multiplicand or divisor magnitude
   logic              neg_res;
   logic              neg_rem;
   logic [CTRL_W-1:0] ctrl;
   logic [WIDTH-1:0]  hi;
   logic [WIDTH-1:0]  lo;

   logic [CTRL_W-1:0] dec_code;
   logic              dec_mul;
   logic              dec_div;
   logic              dec_sgn;
   logic              accept;
   logic              s1_neg;
   logic              s2_neg;
   logic [WIDTH-1:0]  mag1;
   logic [WIDTH-1:0]  mag2;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi;
   logic [WIDTH-1:0]   mul_lo;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [WIDTH-1:0]   div_hi;
   logic [WIDTH-1:0]   div_lo;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // New instructions are only taken while no multi-cycle op is running
   assign accept = bus.valid_i && (state == S_IDLE || state == S_DONE);

   // Decode ALUop/funct into the control code and mul/div class
   always_comb begin
      dec_code = C_INV;
      dec_mul  = 1'b0;
      dec_div  = 1'b0;
      dec_sgn  = 1'b0;
      case (bus.ALUop_i)
         3'b000: begin
            case (bus.funct_i)
               6'h24: dec_code = C_AND;
               6'h25: dec_code = C_OR;
               6'h20: dec_code = C_ADD;
               6'h22: dec_code = C_SUB;
               6'h2A: dec_code = C_SLT;
               6'h10: dec_code = C_MFHI;
               6'h12: dec_code = C_MFLO;
               6'h18: begin dec_code = C_MD; dec_mul = 1'b1; dec_sgn = 1'b1; end
               6'h19: begin dec_code = C_MD; dec_mul = 1'b1; end
               6'h1A: begin dec_code = C_MD; dec_div = 1'b1; dec_sgn = 1'b1; end
               6'h1B: begin dec_code = C_MD; dec_div = 1'b1; end
               default: dec_code = C_INV;
            endcase
         end
         3'b001:  dec_code = C_ADD;
         3'b010:  dec_code = C_LW;
         3'b011:  dec_code = C_SW;
         3'b100:  dec_code = C_SLT;
         3'b101:  dec_code = C_BEQ;
         default: dec_code = C_INV;
      endcase
   end

   // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned
   always_comb begin
      s1_neg = dec_sgn & bus.src1_i[WIDTH-1];
      s2_neg = dec_sgn & bus.src2_i[WIDTH-1];
      mag1   = s1_neg ? (~bus.src1_i + 1'b1) : bus.src1_i;
      mag2   = s2_neg ? (~bus.src2_i + 1'b1) : bus.src2_i;
   end

   // One shift-add and one restoring shift-subtract step, plus sign fix-up of the final step
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      mul_hi    = mul_sum[WIDTH:1];
      mul_lo    = {mul_sum[0], acc_lo[WIDTH-1:1]};
      prod_fix  = neg_res ? (~{mul_hi, mul_lo} + 1'b1) : {mul_hi, mul_lo};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb};
      div_hi    = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      div_lo    = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
      quo_fix   = neg_res ? (~div_lo + 1'b1) : div_lo;
      rem_fix   = neg_rem ? (~div_hi + 1'b1) : div_hi;
   end

   // Control code, FSM, iteration datapath and HI/LO result registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         cnt     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opb     <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         ctrl    <= '0;
         hi      <= '0;
         lo      <= '0;
      end else if (accept) begin
         ctrl <= dec_code;
         if (dec_mul) begin
            state   <= S_MUL;
            cnt     <= CNT_W'(WIDTH);
            acc_hi  <= '0;
            acc_lo  <= mag2;
            opb     <= mag1;
            neg_res <= s1_neg ^ s2_neg;
            neg_rem <= 1'b0;
         end else if (dec_div && bus.src2_i != '0) begin
            state   <= S_DIV;
            cnt     <= CNT_W'(WIDTH);
            acc_hi  <= '0;
            acc_lo  <= mag1;
            opb     <= mag2;
            neg_res <= s1_neg ^ s2_neg;
            neg_rem <= s1_neg;
         end else if (dec_div) begin
            // Divide by zero completes immediately with no error indication
            state <= S_DONE;
            hi    <= bus.src1_i;
            lo    <= '1;
         end else begin
            state <= S_IDLE;
         end
      end else begin
         case (state)
            S_MUL: begin
               acc_hi <= mul_hi;
               acc_lo <= mul_lo;
               cnt    <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= S_DONE;
                  hi    <= prod_fix[2*WIDTH-1:WIDTH];
                  lo    <= prod_fix[WIDTH-1:0];
               end
            end
            S_DIV: begin
               acc_hi <= div_hi;
               acc_lo <= div_lo;
               cnt    <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= S_DONE;
                  hi    <= rem_fix;
                  lo    <= quo_fix;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.ALUCtrl_o = ctrl;
   assign bus.stall_o   = (state == S_MUL) || (state == S_DIV);
   assign bus.md_done_o = (state == S_DONE);
   assign bus.hi_o      = hi;
   assign bus.lo_o      = lo;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb/tb_alu_ctrl_md.sv - self-checking bench for alu_ctrl_md at WIDTH=8
module tb_alu_ctrl_md;

   localparam int W  = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_ctrl_md_if #(.WIDTH(W), .CTRL_W(CW)) bus ();

   alu_ctrl_md #(.WIDTH(W), .CTRL_W(CW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference behaviour: code table, plain arithmetic results, countdown of busy cycles
   function automatic logic [CW-1:0] exp_code(input logic [2:0] op, input logic [5:0] f);
      logic [CW-1:0] c;
      c = 4'hF;
      if (op == 3'd0) begin
         case (f)
            6'h24: c = 4'h0;
            6'h25: c = 4'h1;
            6'h20: c = 4'h2;
            6'h22: c = 4'h3;
            6'h2A: c = 4'h4;
            6'h10: c = 4'h8;
            6'h12: c = 4'h9;
            6'h18, 6'h19, 6'h1A, 6'h1B: c = 4'hA;
            default: c = 4'hF;
         endcase
      end else if (op == 3'd1) c = 4'h2;
      else if (op == 3'd2) c = 4'h5;
      else if (op == 3'd3) c = 4'h6;
      else if (op == 3'd4) c = 4'h4;
      else if (op == 3'd5) c = 4'h7;
      return c;
   endfunction

   function automatic void md_calc(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
      longint sa, sb, ua, ub;
      logic [63:0] p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      h = '0;
      l = '0;
      p = '0;
      q = '0;
      r = '0;
      if (f == 6'h18) begin
         p = sa * sb; h = p[2*W-1:W]; l = p[W-1:0];
      end else if (f == 6'h19) begin
         p = ua * ub; h = p[2*W-1:W]; l = p[W-1:0];
      end else if (b == '0) begin
         h = a; l = '1;
      end else if (f == 6'h1A) begin
         q = sa / sb; r = sa % sb; h = r[W-1:0]; l = q[W-1:0];
      end else begin
         q = ua / ub; r = ua % ub; h = r[W-1:0]; l = q[W-1:0];
      end
   endfunction

   logic [CW-1:0] m_ctrl;
   int            m_busy;
   logic          m_done;
   logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;
   bit            model_on = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_ctrl = '0; m_busy = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
         model_on = 1'b1;
      end else if (model_on) begin
         m_done = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
            end
         end else if (bus.valid_i) begin
            m_ctrl = exp_code(bus.ALUop_i, bus.funct_i);
            if (bus.ALUop_i == 3'd0 && bus.funct_i >= 6'h18 && bus.funct_i <= 6'h1B) begin
               md_calc(bus.funct_i, bus.src1_i, bus.src2_i, p_hi, p_lo);
               if (bus.funct_i >= 6'h1A && bus.src2_i == '0) begin
                  m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
               end else begin
                  m_busy = W;
               end
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the reference
   always @(negedge clk) begin
      if (model_on) begin
         chk("ctrl",  bus.ALUCtrl_o, m_ctrl);
         chk("stall", bus.stall_o,   m_busy > 0);
         chk("done",  bus.md_done_o, m_done);
         chk("hi",    bus.hi_o,      m_hi);
         chk("lo",    bus.lo_o,      m_lo);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.ALUop_i = op; bus.funct_i = f; bus.src1_i = a; bus.src2_i = b; bus.valid_i = 1'b1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      drive(op, f, a, b);
      step();
      bus.valid_i = 1'b0;
   endtask

   task automatic run_md(input string nm, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input int elat);
      int k;
      issue(3'd0, f, a, b);
      k = 1;
      while (!bus.md_done_o && k < 40) begin
         step();
         k++;
      end
      chk({nm, "_lat"}, k, elat);
      chk({nm, "_stall_in_done"}, bus.stall_o, 1'b0);
      chk({nm, "_hi"}, bus.hi_o, eh);
      chk({nm, "_lo"}, bus.lo_o, el);
      step();
   endtask

   typedef struct { logic [2:0] op; logic [5:0] f; logic [3:0] c; } dec_vec_t;
   dec_vec_t dec_tab[13] = '{
      '{3'd0, 6'h24, 4'h0}, '{3'd0, 6'h25, 4'h1}, '{3'd0, 6'h20, 4'h2}, '{3'd0, 6'h2A, 4'h4},
      '{3'd0, 6'h10, 4'h8}, '{3'd0, 6'h12, 4'h9}, '{3'd1, 6'h00, 4'h2}, '{3'd2, 6'h00, 4'h5},
      '{3'd3, 6'h00, 4'h6}, '{3'd4, 6'h00, 4'h4}, '{3'd5, 6'h00, 4'h7}, '{3'd7, 6'h00, 4'hF},
      '{3'd0, 6'h3F, 4'hF}
   };

   initial begin
      bus.valid_i = 1'b0; bus.ALUop_i = '0; bus.funct_i = '0; bus.src1_i = '0; bus.src2_i = '0;
      rst = 1'b1;
      step();
      step();
      chk("rst_ctrl",  bus.ALUCtrl_o, 4'h0);
      chk("rst_stall", bus.stall_o,   1'b0);
      chk("rst_done",  bus.md_done_o, 1'b0);
      chk("rst_hi",    bus.hi_o,      8'h00);
      chk("rst_lo",    bus.lo_o,      8'h00);
      rst = 1'b0;

      issue(3'd0, 6'h22, 8'h00, 8'h00);
      chk("sub_code", bus.ALUCtrl_o, 4'h3);
      chk("sub_stall", bus.stall_o, 1'b0);
      step();
      chk("sub_hold", bus.ALUCtrl_o, 4'h3);
      issue(3'd6, 6'h00, 8'h00, 8'h00);
      chk("op6_code", bus.ALUCtrl_o, 4'hF);
      chk("op6_stall", bus.stall_o, 1'b0);
      foreach (dec_tab[i]) begin
         issue(dec_tab[i].op, dec_tab[i].f, 8'h00, 8'h00);
         chk($sformatf("dec_%0d", i), bus.ALUCtrl_o, dec_tab[i].c);
      end

      issue(3'd0, 6'h18, 8'hFD, 8'h05);
      for (int k = 1; k <= 10; k++) begin
         if (k >= 5 && k <= 9) chk("add_ignored", bus.ALUCtrl_o, 4'hA);
         if (k <= 9) begin
            chk($sformatf("mult_stall_c%0d", k), bus.stall_o, k <= 8);
            chk($sformatf("mult_done_c%0d", k), bus.md_done_o, k == 9);
         end
         if (k == 4) drive(3'd0, 6'h20, 8'h11, 8'h22);
         if (k == 5) bus.valid_i = 1'b0;
         if (k == 9) begin
            chk("mult_hi", bus.hi_o, 8'hFF);
            chk("mult_lo", bus.lo_o, 8'hF1);
            drive(3'd0, 6'h12, 8'h00, 8'h00);
         end
         if (k == 10) begin
            chk("mflo_code", bus.ALUCtrl_o, 4'h9);
            chk("mflo_stall", bus.stall_o, 1'b0);
            bus.valid_i = 1'b0;
         end
         if (k < 10) step();
      end

      run_md("multu",    6'h19, 8'hFD, 8'h05, 8'h04, 8'hF1, 9);
      run_md("divu",     6'h1B, 8'h11, 8'h05, 8'h02, 8'h03, 9);
      run_md("div_neg",  6'h1A, 8'hF9, 8'h02, 8'hFF, 8'hFD, 9);
      run_md("div_ovf",  6'h1A, 8'h80, 8'hFF, 8'h00, 8'h80, 9);
      run_md("mult_mn",  6'h18, 8'h80, 8'h80, 8'h40, 8'h00, 9);
      run_md("mult_m1",  6'h18, 8'h7F, 8'hFF, 8'hFF, 8'h81, 9);
      run_md("div_negd", 6'h1A, 8'h07, 8'hFE, 8'h01, 8'hFD, 9);
      run_md("divu_ff",  6'h1B, 8'hFF, 8'h10, 8'h0F, 8'h0F, 9);
      run_md("div_zero", 6'h1A, 8'h2A, 8'h00, 8'h2A, 8'hFF, 1);

      issue(3'd0, 6'h18, 8'hFD, 8'h05);
      for (int k = 1; k < 5; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_stall", bus.stall_o, 1'b0);
      chk("rst_mid_hi",    bus.hi_o,    8'h00);
      chk("rst_mid_lo",    bus.lo_o,    8'h00);
      chk("rst_mid_ctrl",  bus.ALUCtrl_o, 4'h0);
      for (int k = 0; k < 12; k++) begin
         chk("rst_mid_no_done", bus.md_done_o, 1'b0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
